// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
package clk_div_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_HI = 7'b1110110;  // a and d lit
    localparam logic [6:0] SEG_LO = 7'b1111110;  // a lit
    localparam logic [3:0] AN_ALL = 4'b0000;     // every digit enabled

    // A divisor of 0 has no meaning; treat it as divide-by-1.
    function automatic logic [31:0] div_nonzero(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active divisor, tick pulse and square wave.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = 28,
    parameter int unsigned DIV_INIT = 100_000_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             sync_i,
    output logic             tick_o,
    output logic             clk_out_o
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(div_nonzero(DIV_INIT));
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    // Next-state: shadow captures loads; active divisor only changes at a
    // period boundary (wrap), while idle, or on sync, so no period is cut short.
    always_comb begin
        shadow_d = shadow_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        clk_d    = clk_q;

        if (load_i) begin
            shadow_d = CNT_W'(div_nonzero(32'(div_i)));
        end

        if (sync_i || !en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            act_d = shadow_q;
        end else if (cnt_q == act_q - ONE) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = ~clk_q;
            act_d  = shadow_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            shadow_q <= DIV_RST;
            act_q    <= DIV_RST;
            tick_q   <= 1'b0;
            clk_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
            tick_q   <= tick_d;
            clk_q    <= clk_d;
        end
    end

    assign tick_o    = tick_q;
    assign clk_out_o = clk_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable generator with a 7-segment status display.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 28,
    parameter int unsigned DIV_INIT = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       div_load,
    input  logic [N_CH*CNT_W-1:0] div_in,
    input  logic                  sync,
    input  logic [2:0]            sel,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       clk_out,
    output logic [6:0]            seg,
    output logic [3:0]            an,
    output logic                  dp
);

    logic tick_sel;
    logic clk_sel;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_chan (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .en_i      (en[k]),
            .load_i    (div_load[k]),
            .div_i     (div_in[k*CNT_W +: CNT_W]),
            .sync_i    (sync),
            .tick_o    (tick[k]),
            .clk_out_o (clk_out[k])
        );
    end

    // Channel select for the display; out-of-range selections fall back to channel 0
    always_comb begin
        tick_sel = tick[0];
        clk_sel  = clk_out[0];
        for (int unsigned k = 1; k < N_CH; k++) begin
            if (32'(sel) == k) begin
                tick_sel = tick[k];
                clk_sel  = clk_out[k];
            end
        end
    end

    assign seg = clk_sel ? SEG_HI : SEG_LO;
    assign an  = AN_ALL;
    assign dp  = ~tick_sel;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (N_CH=4, DIV_INIT=4).
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 28;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       div_load;
    logic [N_CH*CNT_W-1:0] div_in;
    logic                  sync;
    logic [2:0]            sel;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       clk_out;
    logic [6:0]            seg;
    logic [3:0]            an;
    logic                  dp;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    clk_div_multi #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DIV_INIT (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_load (div_load),
        .div_in   (div_in),
        .sync     (sync),
        .sel      (sel),
        .tick     (tick),
        .clk_out  (clk_out),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic       e_t0, e_t2, e_c0, e_c2, e_ts, e_cs;
        logic [6:0] e_seg;

        rst_n = 1'b0; en = '0; div_load = '0; div_in = '0; sync = 1'b0; sel = 3'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_clk", 32'(clk_out), 32'd0);
        chk("rst_seg", 32'(seg), 32'(SEG_LO));
        chk("rst_an", 32'(an), 32'd0);
        chk("rst_dp", 32'(dp), 32'd1);

        // Channel 0 at D=4 from reset release
        en = 4'b0001;
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("t1_tick0", 32'(tick[0]), 32'(i % 4 == 0));
            chk("t1_clk0", 32'(clk_out[0]), 32'((i / 4) % 2));
            chk("t1_others", 32'({tick[3:1], clk_out[3:1]}), 32'd0);
            chk("t1_seg", 32'(seg), 32'(((i / 4) % 2 == 1) ? SEG_HI : SEG_LO));
            chk("t1_dp", 32'(dp), 32'(i % 4 != 0));
        end

        // Asynchronous reset mid-period (clk_out[0] is high here)
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk", 32'(clk_out), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_seg", 32'(seg), 32'(SEG_LO));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("arst_first", 32'(tick[0]), 32'(i == 4));
        end

        // Channel 1: D=3, reload to 10 mid-period; channel 0 disabled
        en = '0; div_load = 4'b0010; div_in = '0; div_in[1*CNT_W +: CNT_W] = 28'd3;
        @(negedge clk);
        chk("dis_tick0", 32'(tick[0]), 32'd0);
        chk("dis_clk0", 32'(clk_out[0]), 32'd0);
        div_load = '0;
        @(negedge clk);
        en = 4'b0010;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            chk("t2_tick1", 32'(tick[1]), 32'(n == 3 || n == 6 || n == 16));
            chk("t2_clk1", 32'(clk_out[1]), 32'((n >= 3 && n < 6) || n >= 16));
            if (n == 4) begin
                div_load = 4'b0010; div_in[1*CNT_W +: CNT_W] = 28'd10;
            end else begin
                div_load = '0;
            end
        end

        // Divisors 0 and 1 both act as divide-by-1
        en = '0; div_load = 4'b1100; div_in = '0; div_in[3*CNT_W +: CNT_W] = 28'd1;
        @(negedge clk);
        div_load = '0;
        @(negedge clk);
        en = 4'b1100;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            chk("t3_tick", 32'(tick), 32'(4'b1100));
            chk("t3_clk2", 32'(clk_out[2]), 32'(n % 2));
            chk("t3_clk3", 32'(clk_out[3]), 32'(n % 2));
        end

        // Channels 0 and 2 at D=5 started 2 cycles apart, then sync
        en = '0; div_load = 4'b0101; div_in = '0;
        div_in[0 +: CNT_W] = 28'd5; div_in[2*CNT_W +: CNT_W] = 28'd5;
        @(negedge clk);
        div_load = '0;
        @(negedge clk);
        en = 4'b0001;
        repeat (2) @(negedge clk);
        en = 4'b0101;
        repeat (3) @(negedge clk);
        chk("t4_pre_tick", 32'({tick[2], tick[0]}), 32'(2'b01));
        sync = 1'b1;
        @(negedge clk);
        chk("t4_sync_tick", 32'(tick), 32'd0);
        chk("t4_sync_clk", 32'(clk_out), 32'd0);
        sync = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            chk("t4_tick", 32'({tick[2], tick[0]}), 32'((e == 5) ? 2'b11 : 2'b00));
            chk("t4_clk", 32'({clk_out[2], clk_out[0]}), 32'((e == 5) ? 2'b11 : 2'b00));
        end

        // Drop channel 0 mid-period with a new divisor of 6; channel 2 keeps running
        repeat (2) @(negedge clk);
        en = 4'b0100; div_load = 4'b0001; div_in[0 +: CNT_W] = 28'd6;
        @(negedge clk);
        chk("t5_drop_tick0", 32'(tick[0]), 32'd0);
        chk("t5_drop_clk0", 32'(clk_out[0]), 32'd0);
        div_load = '0;
        @(negedge clk);
        en = 4'b0101;

        // Edges 10..22 after sync: channel 0 restarted at edge 9 (D=6), channel 2 D=5
        for (int e = 10; e <= 22; e++) begin
            @(negedge clk);
            sel = (e <= 15) ? 3'd2 : 3'd7;
            #1;
            e_t2 = (e % 5 == 0);
            e_c2 = ((e / 5) % 2 == 1);
            e_t0 = (e >= 15) && ((e - 9) % 6 == 0);
            e_c0 = (e >= 15) && (((e - 9) / 6) % 2 == 1);
            e_ts = (e <= 15) ? e_t2 : e_t0;
            e_cs = (e <= 15) ? e_c2 : e_c0;
            e_seg = e_cs ? SEG_HI : SEG_LO;
            chk("t5_tick0", 32'(tick[0]), 32'(e_t0));
            chk("t5_clk0", 32'(clk_out[0]), 32'(e_c0));
            chk("t5_tick2", 32'(tick[2]), 32'(e_t2));
            chk("t5_clk2", 32'(clk_out[2]), 32'(e_c2));
            chk("t6_seg", 32'(seg), 32'(e_seg));
            chk("t6_dp", 32'(dp), 32'(!e_ts));
        end
        chk("t6_an", 32'(an), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock-enable generator for Basys3 lab designs running from the 100 MHz board clock. Each of N_CH channels divides the board clock by a runtime-loadable divisor, producing a one-cycle `tick` (a clock enable for downstream flip-flops) and a toggling `clk_out` square wave. A common `sync` input re-phases all channels. A 7-segment status output shows the selected channel's `clk_out` for visual confirmation on the board.

## Interface
- `N_CH`, 4: number of independent channels (1..8).
- `CNT_W`, 28: counter and divisor width in bits.
- `DIV_INIT`, 100_000_000: divisor loaded into every channel at reset; must fit in CNT_W bits.
- `clk` input 1: 100 MHz board clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input N_CH: per-channel run enable.
- `div_load` input N_CH: per-channel strobe; captures that channel's slice of `div_in`.
- `div_in` input N_CH*CNT_W: divisors, channel k in bits [k*CNT_W +: CNT_W].
- `sync` input 1: synchronous restart of every counter.
- `sel` input 3: channel shown on the display; values ≥ N_CH select channel 0.
- `tick` output N_CH: one-cycle pulse every D cycles per channel.
- `clk_out` output N_CH: toggles on every tick, so the period is 2·D cycles.
- `seg` output 7: active-low segments {g,f,e,d,c,b,a}.
- `an` output 4: active-low digit enables; constant 4'b0000.
- `dp` output 1: active-low decimal point; lit while the selected channel's `tick` is high.

## Operation
- Per channel registers: `cnt` (CNT_W), `div_shadow` (CNT_W), `div_act` (CNT_W), `tick`, `clk_out`.
- Divisor value rule: a loaded value of 0 is stored as 1. D denotes the effective divisor.
- `div_load[k]` writes `div_shadow[k]` on the next edge.
- `div_act[k]` takes the value of `div_shadow[k]` in any of these cases:
  - at a wrap (`cnt == div_act-1` while enabled);
  - on any cycle where `en[k]` is low;
  - on `sync`.
- A new divisor therefore never truncates or stretches a period in progress.
- If `div_load` and a wrap fall on the same edge, `div_act` takes the old shadow value and the new value applies from the following period.
- Enabled, no `sync`: `cnt` counts 0..D-1 and wraps to 0.
  - On the wrap edge, `tick` is set for one cycle and `clk_out` is inverted.
  - `tick` is low on all other cycles.
- D = 1: `tick` is held high continuously and `clk_out` toggles every cycle.
- `en[k]` low: `cnt` is held at 0, `tick` is 0 and `clk_out` is forced to 0. Re-enabling starts a fresh period.
- `sync` high (has priority over counting): for all channels, `cnt` goes to 0, `tick` to 0 and `clk_out` to 0. Channels with equal D are then phase-aligned.
- Segment display:
  - selected `clk_out` = 1: `seg` = 7'b1110110 (segments a and d lit);
  - selected `clk_out` = 0: `seg` = 7'b1111110 (segment a lit).
  - `seg` is combinational from registered state.

## Timing
- Reset values: `cnt` = 0, `div_shadow` = `div_act` = DIV_INIT (0 stored as 1), `tick` = 0, `clk_out` = 0. From these, `seg` = 7'b1111110, `an` = 4'b0000 and `dp` = 1.
- First tick after `en` rises (or after `sync`/reset release with `en` high): `tick` is high in the cycle that begins D edges later.
- Steady state: `tick` is high for 1 cycle out of every D cycles.
- `clk_out` has a 50% duty cycle with period 2·D.
- `div_load` to effect: the new value applies at the end of the current period, or immediately if the channel is disabled.
- Reset asserted mid-period: all state clears immediately and asynchronously.
- Reset release: the first count happens on the first rising edge after release.
- `tick` and `clk_out` are direct register outputs with no combinational path from inputs.

## Structure
- Shared package (`clk_div_pkg`) holds:
  - segment constants `SEG_HI` = 7'b1110110 and `SEG_LO` = 7'b1111110;
  - the helper function mapping divisor 0 to 1.
- Sub-module `clk_div_chan` contains one channel's counter, shadow/active divisor, tick and clk_out.
- The top level instantiates N_CH copies in a generate loop and adds the `sel` mux and display decode.

## Test plan
- Reset release, DIV_INIT overridden to 4, `en` = 4'b0001 → channel 0 `tick` high on cycles 4, 8, 12…; `clk_out` toggles at the same edges; other channels stay at 0.
- Channel 1 at D = 3: load 10 at count 1 → remaining ticks at period 3 until the next wrap, then period 10; no short period.
- Load 0 and 1 → both behave as D = 1: `tick` stays high and `clk_out` toggles every cycle.
- Channels 0 and 2 at D = 5 started 2 cycles apart; pulse `sync` → ticks coincide 5 cycles after `sync`; `clk_out` of both is 0 after `sync`.
- `en` dropped mid-period with D = 6 → `tick` = 0 and `clk_out` = 0 the next cycle; re-enable → first tick 6 cycles later.
- `sel` = 2 with channel 2 running, then `sel` = 7 with N_CH = 4 → `seg` alternates `SEG_LO`/`SEG_HI` following channel 2, then follows channel 0; `dp` pulses low with the selected `tick`.
